// File: rtl/pw_packet_filter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pw_fe_stream_if / pw_pkt_stream_if                          |
// | Brief  : Byte-stream interfaces for pw_packet_filter. The front-end  |
// |          stream carries captured UTMI bytes and the packet envelope; |
// |          the packet stream carries filtered bytes with framing and   |
// |          error pulses.                                               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+

// Captured bytes from the front end, qualified by rxvalid, with envelope
interface pw_fe_stream_if;
  logic [7:0] fe_data;
  logic       fe_data_valid;
  logic       rxactive;
  logic       rxerror;

  modport master (output fe_data, fe_data_valid, rxactive, rxerror);
  modport slave  (input  fe_data, fe_data_valid, rxactive, rxerror);
endinterface

// Filtered packet bytes towards the pattern matcher
interface pw_pkt_stream_if;
  logic [7:0] data;
  logic       data_valid;
  logic       sop;
  logic       eop;
  logic       pkt_error;

  modport master (output data, data_valid, sop, eop, pkt_error);
  modport slave  (input  data, data_valid, sop, eop, pkt_error);
endinterface

`default_nettype wire

// File: rtl/pw_packet_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pw_packet_filter                                            |
// | Brief  : USB packet framer/filter. Delimits packets on rxactive,     |
// |          checks the PID check nibble, forwards only packets whose    |
// |          PID is enabled in I_pid_mask and flags bad packets.         |
// |          Optional macro PW_PKT_CRC16_EN adds CRC16 checking of data  |
// |          packets (DATA0/1/2/MDATA).                                  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pw_packet_filter #(
  parameter int pMAX_LEN   = 1027,
  parameter int pCNT_WIDTH = 16
) (
  input  wire logic                  fe_clk,
  input  wire logic                  reset_n,
  input  wire logic                  I_arm,
  input  wire logic [15:0]           I_pid_mask,
  pw_fe_stream_if.slave              fe,
  pw_pkt_stream_if.master            pkt,
  output logic      [3:0]            O_pid,
  output logic      [pCNT_WIDTH-1:0] O_pkt_count
);

  localparam int c_BCNT_W = $clog2(pMAX_LEN + 1);
  localparam logic [c_BCNT_W-1:0] c_MAX_LEN = c_BCNT_W'(pMAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PID  = 3'd1,
    ST_PASS = 3'd2,
    ST_DROP = 3'd3,
    ST_SKIP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_data;
  logic                  r_data_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_pkt_error;
  logic [3:0]            r_pid;
  logic [pCNT_WIDTH-1:0] r_pkt_cnt;
  logic [c_BCNT_W-1:0]   r_byte_cnt;
  logic                  r_arm_q;

  logic w_fwd;       // forward the current byte
  logic w_sop;       // current byte is an accepted PID
  logic w_pid_acc;   // load O_pid from the current byte
  logic w_pid_byte;  // current byte is the first byte of a packet
  logic w_end_pass;  // packet finished cleanly in PASS
  logic w_err;       // dropped packet finished
  logic w_crc_bad;   // finishing data packet has a bad CRC
  logic w_pid_bad;
  logic w_len_full;

  // The upper nibble of a PID is the one's complement of the lower nibble
  assign w_pid_bad  = (fe.fe_data[7:4] != ~fe.fe_data[3:0]);
  assign w_len_full = (r_byte_cnt >= c_MAX_LEN);

  // Next-state and per-byte actions; dropping I_arm forces IDLE with no pulses
  always_comb begin
    w_state_nxt = I_arm ? r_state : ST_IDLE;
    w_fwd       = 1'b0;
    w_sop       = 1'b0;
    w_pid_acc   = 1'b0;
    w_pid_byte  = 1'b0;
    w_end_pass  = 1'b0;
    w_err       = 1'b0;
    if (I_arm) begin
      unique case (r_state)
        // A valid byte in the rxactive rising cycle is already the PID
        ST_IDLE, ST_PID: begin
          if ((r_state == ST_PID) || fe.rxactive) begin
            if (fe.fe_data_valid) begin
              w_pid_byte = 1'b1;
              if (w_pid_bad) begin
                if (fe.rxactive) begin
                  w_state_nxt = ST_DROP;
                end else begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
                end
              end else if (!I_pid_mask[fe.fe_data[3:0]]) begin
                w_state_nxt = fe.rxactive ? ST_SKIP : ST_IDLE;
              end else begin
                w_fwd     = 1'b1;
                w_sop     = 1'b1;
                w_pid_acc = 1'b1;
                if (fe.rxactive) begin
                  w_state_nxt = ST_PASS;
                end else begin
                  w_end_pass  = 1'b1;
                  w_state_nxt = ST_IDLE;
                end
              end
            end else begin
              w_state_nxt = fe.rxactive ? ST_PID : ST_IDLE;
            end
          end
        end
        // A byte beyond the maximum length is the first one not forwarded
        ST_PASS: begin
          if (fe.rxerror || (fe.fe_data_valid && w_len_full)) begin
            if (fe.rxactive) begin
              w_state_nxt = ST_DROP;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_fwd = fe.fe_data_valid;
            if (!fe.rxactive) begin
              w_end_pass  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (!fe.rxactive) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SKIP: begin
          if (!fe.rxactive) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef PW_PKT_CRC16_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_nxt;
  logic [3:0]  w_cur_pid;

  // Reflected CRC16 (poly 0xA001), one byte shifted in LSB first
  function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // CRC runs over payload and CRC bytes; the PID byte only restarts it
  always_comb begin
    w_cur_pid = w_pid_acc ? fe.fe_data[3:0] : r_pid;
    if (w_pid_acc)  w_crc_nxt = 16'hFFFF;
    else if (w_fwd) w_crc_nxt = f_crc16_byte(r_crc, fe.fe_data);
    else            w_crc_nxt = r_crc;
    // Data PIDs 0x3/0x7/0xB/0xF all end in 2'b11; good packets leave 0xB001
    w_crc_bad = (w_cur_pid[1:0] == 2'b11) && (w_crc_nxt != 16'hB001);
  end

  // CRC accumulator
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) r_crc <= 16'hFFFF;
    else          r_crc <= w_crc_nxt;
  end
`else
  assign w_crc_bad = 1'b0;
`endif

  // State register, registered output path, packet and byte counters
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_data       <= 8'h00;
      r_data_valid <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_pkt_error  <= 1'b0;
      r_pid        <= 4'h0;
      r_pkt_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_arm_q      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data_valid <= w_fwd;
      r_sop        <= w_sop;
      r_eop        <= w_end_pass & ~w_crc_bad;
      r_pkt_error  <= w_err | (w_end_pass & w_crc_bad);
      r_arm_q      <= I_arm;
      if (w_fwd)     r_data <= fe.fe_data;
      if (w_pid_acc) r_pid  <= fe.fe_data[3:0];
      if (I_arm && !r_arm_q) begin
        r_pkt_cnt <= '0;
      end else if (w_end_pass && !w_crc_bad && !(&r_pkt_cnt)) begin
        r_pkt_cnt <= r_pkt_cnt + pCNT_WIDTH'(1);
      end
      if (w_pid_byte) begin
        r_byte_cnt <= c_BCNT_W'(1);
      end else if ((r_state == ST_PASS) && fe.fe_data_valid && !(&r_byte_cnt)) begin
        r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
      end
    end
  end

  assign pkt.data       = r_data;
  assign pkt.data_valid = r_data_valid;
  assign pkt.sop        = r_sop;
  assign pkt.eop        = r_eop;
  assign pkt.pkt_error  = r_pkt_error;
  assign O_pid          = r_pid;
  assign O_pkt_count    = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pw_packet_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_pw_packet_filter                                         |
// | Brief  : Directed self-checking bench for pw_packet_filter. Builds   |
// |          with or without PW_PKT_CRC16_EN.                            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_pw_packet_filter;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic [15:0] pid_mask;
  logic [3:0]  pid;
  logic [15:0] pkt_count;

  pw_fe_stream_if  fe_if ();
  pw_pkt_stream_if pkt_if ();

  pw_packet_filter #(.pMAX_LEN(1027), .pCNT_WIDTH(16)) dut (
    .fe_clk      (clk),
    .reset_n     (reset_n),
    .I_arm       (arm),
    .I_pid_mask  (pid_mask),
    .fe          (fe_if),
    .pkt         (pkt_if),
    .O_pid       (pid),
    .O_pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [7:0]  got_q[$];
  int          n_sop;
  int          n_eop;
  int          n_err;
  logic [7:0]  sop_byte;
  logic        eop_with_data;
  logic [15:0] exp_cnt;

  // Reflected CRC16 of payload bytes q[1..], as transmitted (inverted)
  function automatic logic [15:0] usb_crc16(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 1; k < q.size(); k++) begin
      c = c ^ {8'h00, q[k]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    n_sop = 0; n_eop = 0; n_err = 0;
    sop_byte = 8'h00; eop_with_data = 1'b0;
  endtask

  // Apply one cycle of input, then sample the registered response
  task automatic step(input logic v, input logic [7:0] d, input logic act, input logic er);
    fe_if.fe_data_valid = v;
    fe_if.fe_data       = d;
    fe_if.rxactive      = act;
    fe_if.rxerror       = er;
    @(posedge clk);
    #1;
    if (pkt_if.data_valid) got_q.push_back(pkt_if.data);
    if (pkt_if.sop) begin n_sop++; sop_byte = pkt_if.data; end
    if (pkt_if.eop) begin n_eop++; eop_with_data = pkt_if.data_valid; end
    if (pkt_if.pkt_error) n_err++;
  endtask

  // rxactive rises, bytes follow back to back, rxactive falls, idle gap
  task automatic send_pkt(input logic [7:0] q[$], input int err_idx);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < q.size(); k++) step(1'b1, q[k], 1'b1, (k == err_idx));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic bytes_match(input logic [7:0] q[$], input int n);
    if (got_q.size() != n) return 1'b0;
    for (int k = 0; k < n; k++) if (got_q[k] !== q[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; arm = 1'b0; pid_mask = 16'h0000;
    fe_if.fe_data = 8'h00; fe_if.fe_data_valid = 1'b0;
    fe_if.rxactive = 1'b0; fe_if.rxerror = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pkt_if.data_valid, pkt_if.sop, pkt_if.eop, pkt_if.pkt_error} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000",
        {pkt_if.data_valid, pkt_if.sop, pkt_if.eop, pkt_if.pkt_error});
    end
    checks++;
    if ({pkt_if.data, pid, pkt_count} !== 28'h0) begin
      errors++; $display("FAIL reset_values: data %h pid %h count %0d expected all 0",
        pkt_if.data, pid, pkt_count);
    end
    reset_n = 1'b1; arm = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_pass();
    logic [7:0]  q[$];
    logic [15:0] crc;
    q = {8'hC3, 8'h01, 8'h02, 8'h03, 8'h04};
    crc = usb_crc16(q);
    q.push_back(crc[7:0]); q.push_back(crc[15:8]);
    pid_mask = 16'h0008;
    clear_obs();
    send_pkt(q, -1);
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (!bytes_match(q, 7)) begin
      errors++; $display("FAIL pass_bytes: got %0d bytes expected 7 matching", got_q.size());
    end
    checks++;
    if (n_sop !== 1 || sop_byte !== 8'hC3) begin
      errors++; $display("FAIL pass_sop: got %0d on %h expected 1 on c3", n_sop, sop_byte);
    end
    checks++;
    if (n_eop !== 1 || n_err !== 0) begin
      errors++; $display("FAIL pass_eop: got eop %0d err %0d expected 1 0", n_eop, n_err);
    end
    checks++;
    if (pkt_count !== exp_cnt || pid !== 4'h3) begin
      errors++; $display("FAIL pass_count_pid: got %0d %h expected %0d 3", pkt_count, pid, exp_cnt);
    end
  endtask

  task automatic test_skip();
    pid_mask = 16'h0008;
    clear_obs();
    send_pkt({8'hA5, 8'h12, 8'h34}, -1);
    checks++;
    if (got_q.size() != 0 || n_eop != 0 || n_err != 0) begin
      errors++; $display("FAIL skip_sof: got bytes %0d eop %0d err %0d expected 0 0 0",
        got_q.size(), n_eop, n_err);
    end
    checks++;
    if (pkt_count !== exp_cnt || pid !== 4'h3) begin
      errors++; $display("FAIL skip_count_pid: got %0d %h expected %0d 3", pkt_count, pid, exp_cnt);
    end
  endtask

  task automatic test_bad_pid();
    pid_mask = 16'hFFFF;
    clear_obs();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hC4, 1'b1, 1'b0);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (pkt_if.pkt_error !== 1'b1) begin
      errors++; $display("FAIL badpid_err_timing: got %b expected 1", pkt_if.pkt_error);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (pkt_if.pkt_error !== 1'b0 || n_err != 1 || n_eop != 0 || got_q.size() != 0) begin
      errors++; $display("FAIL badpid_pulse: err %0d eop %0d bytes %0d expected 1 0 0",
        n_err, n_eop, got_q.size());
    end
  endtask

  task automatic test_rxerror();
    logic [7:0] q[$];
    q = {8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h66};
    pid_mask = 16'h0008;
    clear_obs();
    send_pkt(q, 3);
    checks++;
    if (!bytes_match(q, 3)) begin
      errors++; $display("FAIL rxerr_bytes: got %0d bytes expected 3 matching", got_q.size());
    end
    checks++;
    if (n_err !== 1 || n_eop !== 0 || pkt_count !== exp_cnt) begin
      errors++; $display("FAIL rxerr_end: err %0d eop %0d count %0d expected 1 0 %0d",
        n_err, n_eop, pkt_count, exp_cnt);
    end
  endtask

  // PID in the rxactive rise cycle, last byte in the rxactive fall cycle
  task automatic test_edges();
    logic [7:0]  q[$];
    logic [15:0] crc;
    q = {8'h4B, 8'hAA};
    crc = usb_crc16(q);
    q.push_back(crc[7:0]); q.push_back(crc[15:8]);
    pid_mask = 16'h0808;
    clear_obs();
    step(1'b1, q[0], 1'b1, 1'b0);
    step(1'b1, q[1], 1'b1, 1'b0);
    step(1'b1, q[2], 1'b1, 1'b0);
    step(1'b1, q[3], 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (!bytes_match(q, 4) || sop_byte !== 8'h4B) begin
      errors++; $display("FAIL edge_bytes: got %0d bytes sop %h expected 4 sop 4b", got_q.size(), sop_byte);
    end
    checks++;
    if (n_eop !== 1 || eop_with_data !== 1'b1) begin
      errors++; $display("FAIL edge_eop: got %0d with_data %b expected 1 1", n_eop, eop_with_data);
    end
    checks++;
    if (pkt_count !== exp_cnt || pid !== 4'hB) begin
      errors++; $display("FAIL edge_count_pid: got %0d %h expected %0d b", pkt_count, pid, exp_cnt);
    end
  endtask

  task automatic test_crc_flip();
    logic [7:0]  q[$];
    logic [15:0] crc;
    q = {8'hC3, 8'h10, 8'h20};
    crc = usb_crc16(q);
    q.push_back(crc[7:0]); q.push_back(crc[15:8] ^ 8'h01);
    pid_mask = 16'h0008;
    clear_obs();
    send_pkt(q, -1);
`ifdef PW_PKT_CRC16_EN
    checks++;
    if (n_err !== 1 || n_eop !== 0 || pkt_count !== exp_cnt || got_q.size() != 5) begin
      errors++; $display("FAIL crc_bad: err %0d eop %0d count %0d bytes %0d expected 1 0 %0d 5",
        n_err, n_eop, pkt_count, got_q.size(), exp_cnt);
    end
`else
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (n_err !== 0 || n_eop !== 1 || pkt_count !== exp_cnt || got_q.size() != 5) begin
      errors++; $display("FAIL crc_off: err %0d eop %0d count %0d bytes %0d expected 0 1 %0d 5",
        n_err, n_eop, pkt_count, got_q.size(), exp_cnt);
    end
`endif
  endtask

  // n bytes: PID, payload, CRC; 1027 is the largest legal packet
  task automatic test_length(input int n, input logic expect_ok, input string name);
    logic [7:0]  q[$];
    logic [15:0] crc;
    q.push_back(8'hC3);
    for (int k = 0; k < n - 3; k++) q.push_back(8'(k));
    crc = usb_crc16(q);
    q.push_back(crc[7:0]); q.push_back(crc[15:8]);
    pid_mask = 16'h0008;
    clear_obs();
    send_pkt(q, -1);
    if (expect_ok) exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (n_eop !== int'(expect_ok) || n_err !== int'(!expect_ok) || pkt_count !== exp_cnt) begin
      errors++; $display("FAIL %s: eop %0d err %0d count %0d expected %0d %0d %0d",
        name, n_eop, n_err, pkt_count, expect_ok, !expect_ok, exp_cnt);
    end
    checks++;
    if (got_q.size() != 1027) begin
      errors++; $display("FAIL %s_bytes: got %0d expected 1027", name, got_q.size());
    end
  endtask

  task automatic test_arm_drop();
    pid_mask = 16'h0008;
    clear_obs();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    arm = 1'b0;
    step(1'b1, 8'h02, 1'b1, 1'b0);
    checks++;
    if (pkt_if.data_valid !== 1'b0) begin
      errors++; $display("FAIL arm_stop: data_valid %b expected 0", pkt_if.data_valid);
    end
    step(1'b1, 8'h03, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (n_eop != 0 || n_err != 0 || got_q.size() != 2 || pkt_count !== exp_cnt) begin
      errors++; $display("FAIL arm_quiet: eop %0d err %0d bytes %0d count %0d expected 0 0 2 %0d",
        n_eop, n_err, got_q.size(), pkt_count, exp_cnt);
    end
    arm = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    exp_cnt = 16'd0;
    checks++;
    if (pkt_count !== exp_cnt || pid !== 4'h3) begin
      errors++; $display("FAIL rearm_clear: count %0d pid %h expected 0 3", pkt_count, pid);
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = 16'd0;
    test_reset();
    test_pass();
    test_skip();
    test_bad_pid();
    test_rxerror();
    test_edges();
    test_crc_flip();
    test_length(1028, 1'b0, "overlong");
    test_arm_drop();
    test_length(1027, 1'b1, "max_len");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
